// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds the PC, reads instruction memory combinationally and queues
// {pc, inst} pairs toward decode; supports redirect and stops after fetching HALT_INST.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] HALT_INST   = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_halted
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(QUEUE_DEPTH);

  logic [31:0]     pc_q;
  logic [31:0]     q_pc   [QUEUE_DEPTH];
  logic [31:0]     q_inst [QUEUE_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            halted_q;
  logic            pop;
  logic            fetch_en;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr    = pc_q;
  assign fetch_halted = halted_q;
  assign out_valid    = (count_q != '0);
  assign out_pc       = out_valid ? q_pc[rd_ptr_q]   : 32'h0;
  assign out_inst     = out_valid ? q_inst[rd_ptr_q] : 32'h0;

  assign pop      = out_valid & out_ready;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign fetch_en = !reset && !redirect_valid && !halted_q && ((count_q < Full) || pop);

  always_ff @(posedge clk) begin
    if (fetch_en) begin
      q_pc[wr_ptr_q]   <= pc_q;
      q_inst[wr_ptr_q] <= imem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (fetch_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        pc_q     <= pc_q + 32'd4;
        if (imem_dout == HALT_INST) begin
          halted_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({fetch_en, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_fetch_unit;

  localparam int unsigned Depth    = 2;
  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [31:0] HaltInst = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_dout, out_inst, out_pc;
  logic        out_valid, fetch_halted;

  logic [31:0] mem [1024];
  assign imem_dout = mem[imem_addr[11:2]];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC   (ResetPc),
    .QUEUE_DEPTH(Depth),
    .HALT_INST  (HaltInst)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_halted  (fetch_halted)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC, queue of {pc, inst}, halted flag.
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic        m_halted;
  bit          checking = 1'b0;
  logic [63:0] head;

  task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == HaltInst);
    return w;
  endfunction

  task automatic model_step();
    bit          pop;
    bit          can;
    logic [31:0] w;
    if (reset) begin
      m_pc     = ResetPc;
      m_q.delete();
      m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_pc     = {redirect_pc[31:2], 2'b00};
      m_q.delete();
      m_halted = 1'b0;
    end else begin
      pop = (m_q.size() != 0) && out_ready;
      can = !m_halted && ((m_q.size() < Depth) || pop);
      if (pop) void'(m_q.pop_front());
      if (can) begin
        w = mem[m_pc[11:2]];
        m_q.push_back({m_pc, w});
        if (w == HaltInst) m_halted = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    checking = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      head = (m_q.size() != 0) ? m_q[0] : 64'h0;
      expect32("imem_addr", imem_addr, m_pc);
      expect32("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
      expect32("out_pc", out_pc, head[63:32]);
      expect32("out_inst", out_inst, head[31:0]);
      expect32("fetch_halted", {31'b0, fetch_halted}, {31'b0, m_halted});
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_0013;

    // Reset then streaming with ready high
    reset = 1'b1; out_ready = 1'b1;
    cycle();
    expect32("rst_addr", imem_addr, 32'h0);
    expect32("rst_valid", {31'b0, out_valid}, 32'h0);
    expect32("rst_inst", out_inst, 32'h0);
    expect32("rst_pc", out_pc, 32'h0);
    expect32("rst_halt", {31'b0, fetch_halted}, 32'h0);
    reset = 1'b0;
    cycle();
    expect32("s1_valid", {31'b0, out_valid}, 32'h1);
    expect32("s1_pc", out_pc, 32'h0);
    expect32("s1_inst", out_inst, 32'h0050_0093);
    cycle();
    expect32("s2_pc", out_pc, 32'h4);
    expect32("s2_inst", out_inst, 32'h0010_0113);
    cycle();
    expect32("s3_pc", out_pc, 32'h8);
    expect32("s3_inst", out_inst, 32'h0020_81B3);

    // Backpressure: queue saturates, PC freezes, nothing lost on release
    reset = 1'b1; out_ready = 1'b0;
    cycle();
    reset = 1'b0;
    repeat (5) cycle();
    expect32("bp_addr", imem_addr, 32'h8);
    expect32("bp_head", out_pc, 32'h0);
    expect32("bp_model_fill", 32'(m_q.size()), 32'(Depth));
    out_ready = 1'b1;
    cycle();
    expect32("bp_rel1", out_pc, 32'h4);
    cycle();
    expect32("bp_rel2", out_pc, 32'h8);
    cycle();
    expect32("bp_rel3", out_pc, 32'hC);

    // Redirect with queue holding 0x4, 0x8
    reset = 1'b1; out_ready = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    expect32("rd_pre_head", out_pc, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    cycle();
    expect32("rd_valid0", {31'b0, out_valid}, 32'h0);
    expect32("rd_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0; out_ready = 1'b1;
    cycle();
    expect32("rd_target", out_pc, 32'h40);

    // Halt at 0xC, drain, then redirect out of halt
    mem[3] = HaltInst;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    expect32("h_pre", {31'b0, fetch_halted}, 32'h0);
    cycle();
    expect32("h_head", out_pc, 32'hC);
    expect32("h_flag", {31'b0, fetch_halted}, 32'h1);
    cycle();
    expect32("h_drained", {31'b0, out_valid}, 32'h0);
    repeat (3) cycle();
    expect32("h_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cycle();
    expect32("h_clear", {31'b0, fetch_halted}, 32'h0);
    redirect_valid = 1'b0;
    cycle();
    expect32("h_refetch", out_pc, 32'h0);

    // Reset beats concurrent redirect with a full queue
    out_ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    cycle();
    expect32("rr_valid", {31'b0, out_valid}, 32'h0);
    expect32("rr_addr", imem_addr, ResetPc);
    reset = 1'b0; redirect_valid = 1'b0;

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    expect32("w_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    cycle();
    expect32("w_pc0", out_pc, 32'hFFFF_FFFC);
    cycle();
    expect32("w_pc1", out_pc, 32'h0);

    // Randomized traffic with sprinkled halt words
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 31) == 0) ? HaltInst : rand_word();
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
